// File: rtl/lcd_stream_drive_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_stream_drive_if
// Description : Pixel beat handshake bundle for lcd_stream_drive.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_stream_drive_if #(
    parameter int DATA_W = 48
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/lcd_stream_drive.sv
`default_nettype none
// ============================================================================
// Module      : lcd_stream_drive
// Description : LCD frame timing generator with brightness-adjusted pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_stream_drive #(
    parameter int IMG_PIX_W   = 8,
    parameter int PIX_PER_CLK = 2,
    parameter int W_SIZE      = 12,
    parameter int W_DELAY     = 12,
    parameter int W_FCNT      = 16
) (
    input  wire logic               HCLK,
    input  wire logic               HRESETn,
    input  wire logic [W_SIZE-1:0]  cfg_width,
    input  wire logic [W_SIZE-1:0]  cfg_height,
    input  wire logic [W_DELAY-1:0] cfg_start_up_delay,
    input  wire logic [W_DELAY-1:0] cfg_vsync_cycle,
    input  wire logic [W_DELAY-1:0] cfg_vsync_delay,
    input  wire logic [W_DELAY-1:0] cfg_hsync_delay,
    input  wire logic [W_DELAY-1:0] cfg_frame_trans_delay,
    input  wire logic [1:0]         cfg_br_mode,
    input  wire logic [IMG_PIX_W-1:0] cfg_br_value,
    input  wire logic               cfg_continuous,
    input  wire logic               start,
    lcd_stream_drive_if.slave       bus,
    output logic                    out_vsync,
    output logic                    out_hsync,
    output logic                    frame_done,
    output logic                    busy,
    output logic [W_FCNT-1:0]       frame_cnt
);
    localparam int c_pix_bits = 3 * IMG_PIX_W;
    localparam int c_data_w   = c_pix_bits * PIX_PER_CLK;
    localparam int c_lane_sh  = $clog2(PIX_PER_CLK);
    localparam logic [W_DELAY:0] c_one_d = 1;
    localparam logic [W_SIZE:0]  c_one_s = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_STARTUP, S_VSYNC, S_VDLY, S_HDLY, S_ACTIVE, S_FTRANS
    } state_t;

    typedef struct packed {
        logic [W_SIZE-1:0]    width;
        logic [W_SIZE-1:0]    height;
        logic [W_DELAY-1:0]   start_up;
        logic [W_DELAY-1:0]   vsync;
        logic [W_DELAY-1:0]   vdly;
        logic [W_DELAY-1:0]   hdly;
        logic [W_DELAY-1:0]   ftrans;
        logic [1:0]           br_mode;
        logic [IMG_PIX_W-1:0] br_value;
    } cfg_t;

    state_t              state_q, state_d;
    cfg_t                cfg_q, cfg_d;
    logic [W_DELAY-1:0]  cnt_q, cnt_d;
    logic [W_SIZE-1:0]   beat_q, beat_d;
    logic [W_SIZE-1:0]   line_q, line_d;
    logic [W_FCNT-1:0]   frame_cnt_q, frame_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [c_data_w-1:0] out_data_q, out_data_d;

    logic [W_DELAY-1:0]  delay_sel;
    logic                delay_done;
    logic                fire;
    logic                last_beat;
    logic [W_SIZE:0]     beats_per_line;
    logic [W_SIZE+2:0]   pix_base;
    logic [c_data_w-1:0] adj_data;

    function automatic logic [IMG_PIX_W-1:0] brighten(
        input logic [IMG_PIX_W-1:0] c,
        input logic [IMG_PIX_W-1:0] v,
        input logic [1:0]           mode
    );
        logic [IMG_PIX_W:0] sum;
        logic [IMG_PIX_W:0] diff;
        sum  = {1'b0, c} + {1'b0, v};
        diff = {1'b0, c} - {1'b0, v};
        case (mode)
            2'd1:    brighten = sum[IMG_PIX_W]  ? '1 : sum[IMG_PIX_W-1:0];
            2'd2:    brighten = diff[IMG_PIX_W] ? '0 : diff[IMG_PIX_W-1:0];
            default: brighten = c;
        endcase
    endfunction

    always_comb begin
        delay_sel = '0;
        case (state_q)
            S_STARTUP: delay_sel = cfg_q.start_up;
            S_VSYNC:   delay_sel = cfg_q.vsync;
            S_VDLY:    delay_sel = cfg_q.vdly;
            S_HDLY:    delay_sel = cfg_q.hdly;
            S_FTRANS:  delay_sel = cfg_q.ftrans;
            default:   delay_sel = '0;
        endcase
    end

    // A programmed delay of zero still occupies one cycle.
    assign delay_done = ({1'b0, cnt_q} + c_one_d) >= {1'b0, delay_sel};

    assign fire           = (state_q == S_ACTIVE) && bus.in_valid;
    assign beats_per_line = ({1'b0, cfg_q.width} + (W_SIZE+1)'(PIX_PER_CLK - 1)) >> c_lane_sh;
    assign last_beat      = ({1'b0, beat_q} + c_one_s) == beats_per_line;
    assign pix_base       = (W_SIZE+3)'(beat_q) << c_lane_sh;

    always_comb begin
        adj_data = '0;
        for (int k = 0; k < PIX_PER_CLK; k++) begin
            for (int c = 0; c < 3; c++) begin
                adj_data[k*c_pix_bits + c*IMG_PIX_W +: IMG_PIX_W] =
                    brighten(bus.in_data[k*c_pix_bits + c*IMG_PIX_W +: IMG_PIX_W],
                             cfg_q.br_value, cfg_q.br_mode);
            end
            // Lanes past the end of the line on a partial final beat.
            if ((pix_base + (W_SIZE+3)'(k)) >= (W_SIZE+3)'(cfg_q.width)) begin
                adj_data[k*c_pix_bits +: c_pix_bits] = '0;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        cnt_d       = '0;
        beat_d      = beat_q;
        line_d      = line_q;
        frame_cnt_d = frame_cnt_q;
        frame_done  = 1'b0;
        out_valid_d = fire;
        out_data_d  = fire ? adj_data : out_data_q;

        case (state_q)
            S_IDLE: begin
                if (start && (cfg_width != '0) && (cfg_height != '0)) begin
                    cfg_d = '{cfg_width, cfg_height, cfg_start_up_delay, cfg_vsync_cycle,
                              cfg_vsync_delay, cfg_hsync_delay, cfg_frame_trans_delay,
                              cfg_br_mode, cfg_br_value};
                    line_d  = '0;
                    beat_d  = '0;
                    state_d = S_STARTUP;
                end
            end
            S_STARTUP: begin
                if (delay_done) state_d = S_VSYNC;
                else            cnt_d   = cnt_q + 1'b1;
            end
            S_VSYNC: begin
                if (delay_done) state_d = S_VDLY;
                else            cnt_d   = cnt_q + 1'b1;
            end
            S_VDLY: begin
                if (delay_done) state_d = S_HDLY;
                else            cnt_d   = cnt_q + 1'b1;
            end
            S_HDLY: begin
                if (delay_done) state_d = S_ACTIVE;
                else            cnt_d   = cnt_q + 1'b1;
            end
            S_ACTIVE: begin
                if (fire) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (({1'b0, line_q} + c_one_s) < {1'b0, cfg_q.height}) begin
                            line_d  = line_q + 1'b1;
                            state_d = S_HDLY;
                        end else begin
                            state_d = S_FTRANS;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FTRANS: begin
                if (delay_done) begin
                    frame_done  = 1'b1;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    line_d      = '0;
                    state_d     = cfg_continuous ? S_VSYNC : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            frame_cnt_q <= frame_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == S_ACTIVE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign out_vsync     = (state_q == S_VSYNC);
    assign out_hsync     = (state_q == S_HDLY) && (cnt_q == '0);
    assign busy          = (state_q != S_IDLE);
    assign frame_cnt     = frame_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_lcd_stream_drive.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_stream_drive
// Description : Directed self-checking bench for lcd_stream_drive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_stream_drive;
    localparam int DW = 48;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [11:0] cfg_width, cfg_height;
    logic [11:0] cfg_start_up_delay, cfg_vsync_cycle, cfg_vsync_delay;
    logic [11:0] cfg_hsync_delay, cfg_frame_trans_delay;
    logic [1:0]  cfg_br_mode;
    logic [7:0]  cfg_br_value;
    logic        cfg_continuous;
    logic        start;
    logic        out_vsync, out_hsync, frame_done, busy;
    logic [15:0] frame_cnt;

    int n_pass  = 0;
    int n_total = 0;

    lcd_stream_drive_if #(.DATA_W(DW)) bus ();

    lcd_stream_drive #(
        .IMG_PIX_W(8), .PIX_PER_CLK(2), .W_SIZE(12), .W_DELAY(12), .W_FCNT(16)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_start_up_delay(cfg_start_up_delay), .cfg_vsync_cycle(cfg_vsync_cycle),
        .cfg_vsync_delay(cfg_vsync_delay), .cfg_hsync_delay(cfg_hsync_delay),
        .cfg_frame_trans_delay(cfg_frame_trans_delay),
        .cfg_br_mode(cfg_br_mode), .cfg_br_value(cfg_br_value),
        .cfg_continuous(cfg_continuous), .start(start),
        .bus(bus),
        .out_vsync(out_vsync), .out_hsync(out_hsync), .frame_done(frame_done),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 HCLK = ~HCLK;

    task automatic set_cfg(input int w, input int h, input int su, input int vs,
                           input int vd, input int hs, input int ft,
                           input logic [1:0] mode, input logic [7:0] val, input logic cont);
        cfg_width = 12'(w); cfg_height = 12'(h);
        cfg_start_up_delay = 12'(su); cfg_vsync_cycle = 12'(vs);
        cfg_vsync_delay = 12'(vd); cfg_hsync_delay = 12'(hs);
        cfg_frame_trans_delay = 12'(ft);
        cfg_br_mode = mode; cfg_br_value = val; cfg_continuous = cont;
    endtask

    // Leaves the bench at the negedge of the first cycle after acceptance.
    task automatic pulse_start();
        @(negedge HCLK); start = 1'b1;
        @(negedge HCLK); start = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        start = 1'(($urandom));
        bus.in_valid = 1'($urandom);
        bus.in_data = 48'({$urandom, $urandom});
        set_cfg(int'($urandom_range(4095)), int'($urandom_range(4095)), 3, 3, 3, 3, 3,
                2'($urandom), 8'($urandom), 1'($urandom));
        repeat (3) @(negedge HCLK);
        n_total++;
        if ({out_vsync, out_hsync, frame_done, busy, bus.in_ready, bus.out_valid} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {out_vsync, out_hsync, frame_done, busy, bus.in_ready, bus.out_valid});
        else n_pass++;
        n_total++;
        if (frame_cnt !== 16'h0) $display("FAIL reset_fcnt: got %0h expected 0", frame_cnt);
        else n_pass++;
        n_total++;
        if (bus.out_data !== 48'h0) $display("FAIL reset_data: got %0h expected 0", bus.out_data);
        else n_pass++;
        start = 1'b0; bus.in_valid = 1'b0;
        @(negedge HCLK); HRESETn = 1'b1;
        begin
            int busy_seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge HCLK);
                if (busy) busy_seen++;
            end
            n_total++;
            if (busy_seen !== 0) $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_seen);
            else n_pass++;
        end
    endtask

    task automatic test_timing_frame();
        int n_vs = 0, n_hs = 0, n_ov = 0, n_fd = 0, fd_cyc = -1, hs2_cyc = -1;
        int line1_fires = 0, first_ov = -1;
        set_cfg(8, 2, 5, 3, 3, 4, 6, 2'd0, 8'h00, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = 48'h112233_445566;
        @(negedge HCLK); start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge HCLK); start = 1'b0;
            if (out_vsync) n_vs++;
            if (out_hsync) begin n_hs++; if (n_hs == 2) hs2_cyc = k; end
            if (bus.in_ready && bus.in_valid && hs2_cyc < 0) line1_fires++;
            if (bus.out_valid) begin n_ov++; if (first_ov < 0) first_ov = k; end
            if (frame_done) begin n_fd++; fd_cyc = k; end
        end
        n_total++;
        if (n_vs !== 3) $display("FAIL tf_vsync_len: got %0d expected 3", n_vs); else n_pass++;
        n_total++;
        if (n_hs !== 2) $display("FAIL tf_hsync_pulses: got %0d expected 2", n_hs); else n_pass++;
        n_total++;
        if (line1_fires !== 4) $display("FAIL tf_line_beats: got %0d expected 4", line1_fires); else n_pass++;
        n_total++;
        if (n_ov !== 8) $display("FAIL tf_out_beats: got %0d expected 8", n_ov); else n_pass++;
        n_total++;
        if (first_ov !== 17) $display("FAIL tf_first_out: got %0d expected 17", first_ov); else n_pass++;
        n_total++;
        if (n_fd !== 1) $display("FAIL tf_done_len: got %0d expected 1", n_fd); else n_pass++;
        n_total++;
        if (fd_cyc !== 33) $display("FAIL tf_done_cycle: got %0d expected 33", fd_cyc); else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd1) $display("FAIL tf_frame_cnt: got %0d expected 1", frame_cnt); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL tf_idle_after: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic run_bright(input string name, input logic [1:0] mode,
                              input logic [47:0] din, input logic [47:0] exp_data);
        logic [47:0] got = '0;
        int seen = 0;
        set_cfg(2, 1, 0, 0, 0, 0, 0, mode, 8'h50, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = din;
        pulse_start();
        for (int k = 0; k < 30; k++) begin
            if (bus.out_valid && seen == 0) begin got = bus.out_data; seen = 1; end
            @(negedge HCLK);
        end
        n_total++;
        if (seen == 0) $display("FAIL %s: no output beat within 30 cycles", name);
        else if (got !== exp_data) $display("FAIL %s: got %h expected %h", name, got, exp_data);
        else n_pass++;
    endtask

    task automatic test_brightness();
        run_bright("br_add", 2'd1, 48'h00FF50_F01080, 48'h50FFA0_FF60D0);
        run_bright("br_sub", 2'd2, 48'h00FF50_F01080, 48'h00AF00_A00030);
        run_bright("br_bypass0", 2'd0, 48'h00FF50_F01080, 48'h00FF50_F01080);
        run_bright("br_bypass3", 2'd3, 48'h123456_789ABC, 48'h123456_789ABC);
    endtask

    task automatic test_backpressure();
        int a = 0, n_fire = 0, n_ov = 0, lat_err = 0, data_err = 0;
        logic prev_fire = 1'b0;
        logic [47:0] prev_data = '0;
        set_cfg(8, 1, 1, 1, 1, 1, 1, 2'd0, 8'h00, 1'b0);
        bus.in_valid = 1'b0;
        pulse_start();
        for (int k = 0; k < 80; k++) begin
            if (bus.out_valid !== prev_fire) lat_err++;
            if (bus.out_valid) begin
                n_ov++;
                if (bus.out_data !== prev_data) data_err++;
            end
            if (bus.in_ready) begin
                bus.in_valid = ((a % 3) == 0);
                bus.in_data  = 48'(n_fire + 1) * 48'h010101_010101;
                a++;
            end else begin
                bus.in_valid = 1'b0;
            end
            prev_fire = bus.in_ready && bus.in_valid;
            if (prev_fire) begin prev_data = bus.in_data; n_fire++; end
            @(negedge HCLK);
        end
        n_total++;
        if (n_fire !== 4) $display("FAIL bp_accepted: got %0d expected 4", n_fire); else n_pass++;
        n_total++;
        if (n_ov !== 4) $display("FAIL bp_out_beats: got %0d expected 4", n_ov); else n_pass++;
        n_total++;
        if (lat_err !== 0) $display("FAIL bp_latency: got %0d bad cycles expected 0", lat_err); else n_pass++;
        n_total++;
        if (data_err !== 0) $display("FAIL bp_data: got %0d bad beats expected 0", data_err); else n_pass++;
        n_total++;
        if (a !== 10) $display("FAIL bp_line_len: got %0d expected 10", a); else n_pass++;
        n_total++;
        if (bus.out_data !== 48'h040404_040404)
            $display("FAIL bp_data_hold: got %h expected 040404040404", bus.out_data);
        else n_pass++;
    endtask

    task automatic test_partial();
        int n_ov = 0;
        logic [47:0] first_d = '0, last_d = '0;
        set_cfg(7, 1, 1, 1, 1, 1, 1, 2'd0, 8'h00, 1'b0);
        bus.in_valid = 1'b1; bus.in_data = '1;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            if (bus.out_valid) begin
                if (n_ov == 0) first_d = bus.out_data;
                last_d = bus.out_data;
                n_ov++;
            end
            @(negedge HCLK);
        end
        n_total++;
        if (n_ov !== 4) $display("FAIL pt_beats: got %0d expected 4", n_ov); else n_pass++;
        n_total++;
        if (first_d !== 48'hFFFFFF_FFFFFF) $display("FAIL pt_full_beat: got %h expected ffffffffffff", first_d);
        else n_pass++;
        n_total++;
        if (last_d !== 48'h000000_FFFFFF) $display("FAIL pt_last_lane: got %h expected 000000ffffff", last_d);
        else n_pass++;
    endtask

    task automatic test_zero_size();
        int busy_seen = 0;
        set_cfg(0, 2, 1, 1, 1, 1, 1, 2'd0, 8'h00, 1'b0);
        pulse_start();
        for (int k = 0; k < 8; k++) begin if (busy) busy_seen++; @(negedge HCLK); end
        set_cfg(4, 0, 1, 1, 1, 1, 1, 2'd0, 8'h00, 1'b0);
        pulse_start();
        for (int k = 0; k < 8; k++) begin if (busy) busy_seen++; @(negedge HCLK); end
        n_total++;
        if (busy_seen !== 0) $display("FAIL zero_size_start: got %0d busy cycles expected 0", busy_seen);
        else n_pass++;
    endtask

    task automatic test_continuous();
        int dones = 0, vs_follow = 0;
        logic prev_done = 1'b0;
        HRESETn = 1'b0; @(negedge HCLK); HRESETn = 1'b1;
        set_cfg(2, 1, 10, 1, 1, 1, 1, 2'd0, 8'h00, 1'b1);
        bus.in_valid = 1'b1;
        pulse_start();
        for (int k = 0; k < 120; k++) begin
            if (prev_done && dones < 3 && out_vsync) vs_follow++;
            if (prev_done && dones == 2) cfg_continuous = 1'b0;
            prev_done = frame_done;
            if (frame_done) dones++;
            @(negedge HCLK);
        end
        n_total++;
        if (dones !== 3) $display("FAIL cont_done_pulses: got %0d expected 3", dones); else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd3) $display("FAIL cont_frame_cnt: got %0d expected 3", frame_cnt); else n_pass++;
        n_total++;
        if (vs_follow !== 2) $display("FAIL cont_no_startup: got %0d expected 2", vs_follow); else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL cont_stop: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int waited = 0, dones = 0, busy_seen = 0;
        set_cfg(8, 2, 1, 1, 1, 1, 1, 2'd0, 8'h00, 1'b0);
        bus.in_valid = 1'b1;
        pulse_start();
        while (!bus.in_ready && waited < 50) begin @(negedge HCLK); waited++; end
        n_total++;
        if (!bus.in_ready) $display("FAIL rm_reach_active: got in_ready=0 after 50 cycles expected 1");
        else n_pass++;
        @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        n_total++;
        if ({busy, bus.in_ready, frame_done, frame_cnt} !== 19'h0)
            $display("FAIL rm_async_clear: got busy=%0b rdy=%0b done=%0b fcnt=%0d expected all 0",
                     busy, bus.in_ready, frame_done, frame_cnt);
        else n_pass++;
        @(negedge HCLK); HRESETn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (frame_done) dones++;
            if (busy) busy_seen++;
            @(negedge HCLK);
        end
        n_total++;
        if (dones !== 0 || busy_seen !== 0)
            $display("FAIL rm_aborted: got %0d done / %0d busy cycles expected 0/0", dones, busy_seen);
        else n_pass++;
    endtask

    initial begin
        start = 1'b0; HRESETn = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 2'd0, 8'h00, 1'b0);
        test_reset();
        test_timing_frame();
        test_brightness();
        test_backpressure();
        test_partial();
        test_zero_size();
        test_continuous();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lcd_stream_drive.md
Name: lcd_stream_drive

Overview:
- Parametrised next-generation LCD pixel driver for the AHB-configured display path.
- Generates frame timing (start-up, vsync, vsync delay, per-line hsync delay, inter-frame delay).
- Accepts PIX_PER_CLK RGB pixels per beat from upstream over a ready/valid handshake and applies per-component brightness add/subtract with saturation.
- Adds continuous-frame mode, a frame counter and upstream backpressure.

Parameters:
- IMG_PIX_W, 8, bits per colour component.
- PIX_PER_CLK, 2, pixels per beat (1, 2 or 4).
- W_SIZE, 12, width/height register width.
- W_DELAY, 12, delay register width.
- W_FCNT, 16, frame counter width.

Ports:
- HCLK  in  1  system clock.
- HRESETn  in  1  asynchronous active-low reset.
- cfg_width  in  W_SIZE  pixels per line.
- cfg_height  in  W_SIZE  lines per frame.
- cfg_start_up_delay  in  W_DELAY  cycles before the first frame.
- cfg_vsync_cycle  in  W_DELAY  vsync pulse length.
- cfg_vsync_delay  in  W_DELAY  cycles from vsync end to the first line.
- cfg_hsync_delay  in  W_DELAY  per-line blanking cycles.
- cfg_frame_trans_delay  in  W_DELAY  cycles after the last line.
- cfg_br_mode  in  2  0 bypass, 1 add, 2 subtract, 3 bypass.
- cfg_br_value  in  IMG_PIX_W  brightness offset.
- cfg_continuous  in  1  auto-restart frames.
- start  in  1  frame start request.
- in_valid  in  1  upstream beat valid.
- in_data  in  3*IMG_PIX_W*PIX_PER_CLK  pixel k occupies bits [k*3W +: 3W], ordered {R,G,B} with R in the MSBs.
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- out_valid  out  1  output beat valid.
- out_data  out  same as in_data  brightness-adjusted pixels.
- out_vsync  out  1  vertical sync.
- out_hsync  out  1  line-start pulse.
- frame_done  out  1  one-cycle end-of-frame pulse.
- busy  out  1  not IDLE.
- frame_cnt  out  W_FCNT  completed frames, wraps.

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is asynchronous, active-low. While low, all outputs are 0, FSM is IDLE and counters are 0. Reset mid-frame aborts immediately with no frame_done.
- Delay encoding: every delay value N lasts max(N,1) cycles.
- Config latch: all cfg_* are sampled on the cycle start is accepted and held for the whole run. cfg_continuous is the exception: it is re-sampled at each frame end.
- IDLE: start=1 with cfg_width!=0 and cfg_height!=0 → STARTUP. Otherwise start is ignored. start outside IDLE is ignored.
- STARTUP: start-up delay → VSYNC.
- VSYNC: out_vsync=1 for vsync_cycle cycles → VDLY.
- VDLY: vsync_delay cycles → HDLY.
- HDLY: out_hsync=1 on the first cycle only. Lasts hsync_delay cycles → ACTIVE.
- ACTIVE: in_ready=1.
  - Beats per line = ceil(width/PIX_PER_CLK). The beat counter advances only on handshake.
  - in_valid low stalls: no output, counters hold, no timeout.
  - On the last beat of a line: if line < height-1 → HDLY, else → FTRANS.
  - For a partial last beat, unused pixel lanes of out_data are forced to 0.
- FTRANS: frame_trans_delay cycles.
  - frame_done pulses in the final cycle and frame_cnt increments in the same cycle.
  - Next state is VSYNC if cfg_continuous=1 (no start-up delay), else IDLE.
- in_ready is 0 in every state except ACTIVE.
- Datapath: registered, latency 1. A handshake in cycle t gives out_valid=1 and out_data in cycle t+1. out_valid is 0 otherwise; out_data holds its last value.
- Brightness, per component:
  - add: min(c+v, 2^W-1).
  - sub: max(c-v, 0).
  - Computed at W+1 bits, then saturated.
- busy = (state != IDLE).

Test Plan:
- Reset: HRESETn=0 with random inputs → all outputs 0. Release, no start → busy stays 0.
- Timing frame: width=8, height=2, PIX_PER_CLK=2, delays start-up=5/vsync_cycle=3/vsync_delay=3/hsync=4/ftrans=6, in_valid held 1.
  - out_vsync high exactly 3 cycles.
  - 2 hsync pulses.
  - 4 out_valid beats per line.
  - frame_done is 1 cycle at the end of FTRANS, frame_cnt=1.
  - Total cycles from start to frame_done = 5+3+3+2*(4+4)+6 = 33.
- Brightness: cfg_br_mode=1, value 0x50.
  - Pixel R=0xF0 → 0xFF; G=0x10 → 0x60.
  - With cfg_br_mode=2: 0x10 → 0x00, 0xF0 → 0xA0.
  - With cfg_br_mode=0: passthrough.
- Backpressure: in_valid toggles 1,0,0,1… within a line → output beats equal accepted beats, each 1 cycle after its handshake; line length is extended by the stall cycles.
- Continuous and boundaries:
  - cfg_continuous=1 for 3 frames, then cleared → frame_cnt=3, and STARTUP is not re-entered between frames.
  - width=7, PIX_PER_CLK=2 → 4 beats per line, last beat lane 1 = 0.
  - width=0 start → ignored.
  - HRESETn pulsed mid-ACTIVE → IDLE, no frame_done.
